display_scanout: RTL and testbench

//  Parametrised framebuffer scan-out engine; successor to the fixed 800x480 VGA/LCD driver pair.

---
 rtl/display_pkg.sv | 51 +++++
 rtl/display_timing_gen.sv | 66 ++++++
 rtl/display_scanout.sv | 206 ++++++++++++++++++++
 tb/tb_display_scanout.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg
//   Shared types and helpers for the display scan-out engine.
//   rgb888_t          : packed {r, g, b} colour, 8 bits per channel
//   pal_idx_t         : palette index for the default 4-bit pixel format
//   timing_t          : horizontal/vertical timing description
//   DEFAULT_TIMING    : 800x480 panel timing used as parameter defaults
//   ctl_t             : per-pixel control bits carried down the alignment pipe
//   default_palette() : grey-ramp reset value for palette entry idx
//   Optional feature macro used by the engine: DISPLAY_SCANOUT_TEST_PATTERN_EN
package display_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    localparam int DEF_PIX_W = 4;
    typedef logic [DEF_PIX_W-1:0] pal_idx_t;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } timing_t;

    localparam timing_t DEFAULT_TIMING = '{
        h_active: 800, h_fp: 40, h_sync: 48, h_bp: 88,
        v_active: 480, v_fp: 13, v_sync: 3,  v_bp: 32
    };

    typedef struct packed {
        logic active;
        logic hsync;   // asserted (polarity-independent)
        logic vsync;   // asserted (polarity-independent)
        logic first;   // pixel (0,0)
    } ctl_t;

    // Evenly spaced grey levels so that the top entry is full white.
    function automatic rgb888_t default_palette(input int idx, input int pix_w);
        logic [7:0] lvl;
        lvl = 8'(idx * (255 / ((1 << pix_w) - 1)));
        return '{r: lvl, g: lvl, b: lvl};
    endfunction

endpackage

// File: rtl/display_timing_gen.sv
// display_timing_gen
//   Horizontal/vertical pixel counters and the per-pixel control bits derived
//   from them. Counters advance only on pix_ce.
//   Ports:
//     clock, reset (sync, active-high), pix_ce
//     ctl     : active / hsync / vsync / first for the current pixel
//     bar_idx : h[PIX_W+3:4], only with DISPLAY_SCANOUT_TEST_PATTERN_EN
module display_timing_gen
    import display_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 48,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 13,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 32,
    parameter int PIX_W    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pix_ce,
`ifdef DISPLAY_SCANOUT_TEST_PATTERN_EN
    output logic [PIX_W-1:0] bar_idx,
`endif
    output ctl_t             ctl
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // h is kept wide enough for the 16-pixel bar index even on tiny rasters.
    localparam int H_W = ($clog2(H_TOTAL) > PIX_W + 4) ? $clog2(H_TOTAL) : PIX_W + 4;
    localparam int V_W = $clog2(V_TOTAL);

    logic [H_W-1:0] h_reg;
    logic [V_W-1:0] v_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            h_reg <= '0;
            v_reg <= '0;
        end else if (pix_ce) begin
            if (h_reg == H_W'(H_TOTAL - 1)) begin
                h_reg <= '0;
                v_reg <= (v_reg == V_W'(V_TOTAL - 1)) ? '0 : v_reg + 1'b1;
            end else begin
                h_reg <= h_reg + 1'b1;
            end
        end
    end

    always_comb begin
        ctl.active = (h_reg < H_W'(H_ACTIVE)) && (v_reg < V_W'(V_ACTIVE));
        ctl.hsync  = (h_reg >= H_W'(H_ACTIVE + H_FP)) &&
                     (h_reg <  H_W'(H_ACTIVE + H_FP + H_SYNC));
        ctl.vsync  = (v_reg >= V_W'(V_ACTIVE + V_FP)) &&
                     (v_reg <  V_W'(V_ACTIVE + V_FP + V_SYNC));
        ctl.first  = (h_reg == '0) && (v_reg == '0);
    end

`ifdef DISPLAY_SCANOUT_TEST_PATTERN_EN
    assign bar_idx = h_reg[PIX_W+3:4];
`endif

endmodule

// File: rtl/display_scanout.sv
// display_scanout
//   Framebuffer scan-out engine: timing generation, linear framebuffer fetch,
//   16-entry writable palette, aligned LCD (RGB888) and VGA (RGB555 MSBs) outputs.
//   Ports:
//     clock, reset (sync, active-high), pix_ce (pixel enable)
//     fb_rd, fb_addr, fb_data           : framebuffer read port (FB_LAT beats)
//     pal_we, pal_idx, pal_rgb          : palette write port
//     lcd_de/hsync/vsync/red/green/blue : LCD head
//     vga_hsync/vsync/red/green/blue    : VGA head
//     frame_start                       : one-clock pulse as pixel (0,0) leaves
//     test_mode                         : bar pattern select, only with
//                                         DISPLAY_SCANOUT_TEST_PATTERN_EN
//   Latency from fb_rd to the matching output pixel is FB_LAT+1 pix_ce beats.
module display_scanout
    import display_pkg::*;
#(
    parameter int H_ACTIVE = DEFAULT_TIMING.h_active,
    parameter int H_FP     = DEFAULT_TIMING.h_fp,
    parameter int H_SYNC   = DEFAULT_TIMING.h_sync,
    parameter int H_BP     = DEFAULT_TIMING.h_bp,
    parameter int V_ACTIVE = DEFAULT_TIMING.v_active,
    parameter int V_FP     = DEFAULT_TIMING.v_fp,
    parameter int V_SYNC   = DEFAULT_TIMING.v_sync,
    parameter int V_BP     = DEFAULT_TIMING.v_bp,
    parameter int PIX_W    = 4,
    parameter int FB_LAT   = 1,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    localparam int ADDR_W  = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pix_ce,
    output logic              fb_rd,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [PIX_W-1:0]  fb_data,
    input  logic              pal_we,
    input  logic [PIX_W-1:0]  pal_idx,
    input  logic [23:0]       pal_rgb,
`ifdef DISPLAY_SCANOUT_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic              lcd_de,
    output logic              lcd_hsync,
    output logic              lcd_vsync,
    output logic [7:0]        lcd_red,
    output logic [7:0]        lcd_green,
    output logic [7:0]        lcd_blue,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic [4:0]        vga_red,
    output logic [4:0]        vga_green,
    output logic [4:0]        vga_blue,
    output logic              frame_start
);

    localparam int NUM_PIX   = H_ACTIVE * V_ACTIVE;
    localparam int PAL_DEPTH = 1 << PIX_W;

    genvar gi;

    // ---------------- timing ----------------
    ctl_t ctl_now;
`ifdef DISPLAY_SCANOUT_TEST_PATTERN_EN
    logic [PIX_W-1:0] bar_now;
`endif

    display_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .PIX_W(PIX_W)
    ) u_timing (
        .clock  (clock),
        .reset  (reset),
        .pix_ce (pix_ce),
`ifdef DISPLAY_SCANOUT_TEST_PATTERN_EN
        .bar_idx(bar_now),
`endif
        .ctl    (ctl_now)
    );

    // ---------------- fetch ----------------
    // Reset gates the strobe so no read is issued while counters sit at (0,0).
    logic [ADDR_W-1:0] addr_reg;

    assign fb_rd   = ctl_now.active && pix_ce && !reset;
    assign fb_addr = addr_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_reg <= '0;
        end else if (fb_rd) begin
            addr_reg <= (addr_reg == ADDR_W'(NUM_PIX - 1)) ? '0 : addr_reg + 1'b1;
        end
    end

    // ---------------- alignment pipe ----------------
    // FB_LAT stages here plus the output register match the read latency
    // plus the palette lookup.
    ctl_t ctl_pipe [FB_LAT+1];
    assign ctl_pipe[0] = ctl_now;

    generate
        for (gi = 0; gi < FB_LAT; gi++) begin : g_align
            ctl_t stage_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    stage_reg <= '0;
                end else if (pix_ce) begin
                    stage_reg <= ctl_pipe[gi];
                end
            end
            assign ctl_pipe[gi+1] = stage_reg;
        end
    endgenerate

    // ---------------- pixel index ----------------
    logic [PIX_W-1:0] pix_idx;

`ifdef DISPLAY_SCANOUT_TEST_PATTERN_EN
    logic [PIX_W-1:0] bar_pipe [FB_LAT+1];
    assign bar_pipe[0] = bar_now;

    generate
        for (gi = 0; gi < FB_LAT; gi++) begin : g_bar
            logic [PIX_W-1:0] stage_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    stage_reg <= '0;
                end else if (pix_ce) begin
                    stage_reg <= bar_pipe[gi];
                end
            end
            assign bar_pipe[gi+1] = stage_reg;
        end
    endgenerate

    assign pix_idx = test_mode ? bar_pipe[FB_LAT] : fb_data;
`else
    assign pix_idx = fb_data;
`endif

    // ---------------- palette ----------------
    // Register per entry so it can reset to the ramp; a write lands on the
    // edge, so a lookup on that same edge still sees the previous colour.
    rgb888_t pal_tbl [PAL_DEPTH];

    generate
        for (gi = 0; gi < PAL_DEPTH; gi++) begin : g_pal
            rgb888_t entry_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    entry_reg <= default_palette(gi, PIX_W);
                end else if (pal_we && (pal_idx == PIX_W'(gi))) begin
                    entry_reg <= pal_rgb;
                end
            end
            assign pal_tbl[gi] = entry_reg;
        end
    endgenerate

    // ---------------- output registers ----------------
    ctl_t    aligned;
    rgb888_t lookup;
    logic    de_reg;
    logic    hs_reg;
    logic    vs_reg;
    logic    fs_reg;
    rgb888_t rgb_reg;

    assign aligned = ctl_pipe[FB_LAT];
    assign lookup  = pal_tbl[pix_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            de_reg  <= 1'b0;
            hs_reg  <= ~HS_POL;
            vs_reg  <= ~VS_POL;
            fs_reg  <= 1'b0;
            rgb_reg <= '0;
        end else begin
            // Cleared on idle clocks so the pulse lasts one clock, not one beat.
            fs_reg <= pix_ce && aligned.first;
            if (pix_ce) begin
                de_reg  <= aligned.active;
                hs_reg  <= aligned.hsync ? HS_POL : ~HS_POL;
                vs_reg  <= aligned.vsync ? VS_POL : ~VS_POL;
                rgb_reg <= aligned.active ? lookup : '0;
            end
        end
    end

    assign lcd_de      = de_reg;
    assign lcd_hsync   = hs_reg;
    assign lcd_vsync   = vs_reg;
    assign lcd_red     = rgb_reg.r;
    assign lcd_green   = rgb_reg.g;
    assign lcd_blue    = rgb_reg.b;
    assign vga_hsync   = hs_reg;
    assign vga_vsync   = vs_reg;
    assign vga_red     = rgb_reg.r[7:3];
    assign vga_green   = rgb_reg.g[7:3];
    assign vga_blue    = rgb_reg.b[7:3];
    assign frame_start = fs_reg;

endmodule

// File: tb/tb_display_scanout.sv
// tb_display_scanout
//   Directed bench for display_scanout on a reduced 40x6 raster
//   (H: 40/4/6/8 = 58, V: 6/2/2/3 = 13, frame = 754 beats), FB_LAT = 2.
//   With DISPLAY_SCANOUT_TEST_PATTERN_EN defined the bar pattern is exercised too.
module tb_display_scanout;
    import display_pkg::*;

    localparam int HA = 40, HFP = 4, HSW = 6, HBP = 8;
    localparam int VA = 6,  VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;   // 58
    localparam int VT = VA + VFP + VSW + VBP;   // 13
    localparam int FRAME = HT * VT;             // 754
    localparam int LAT = 2;
    localparam int L = LAT + 1;
    localparam int AW = 8;
    localparam int NPIX = HA * VA;              // 240

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          pix_ce = 1'b0;
    logic          fb_rd;
    logic [AW-1:0] fb_addr;
    logic [3:0]    fb_data;
    logic          pal_we = 1'b0;
    logic [3:0]    pal_idx = 4'd0;
    logic [23:0]   pal_rgb = 24'd0;
`ifdef DISPLAY_SCANOUT_TEST_PATTERN_EN
    logic          test_mode = 1'b0;
`endif
    logic          lcd_de, lcd_hsync, lcd_vsync;
    logic [7:0]    lcd_red, lcd_green, lcd_blue;
    logic          vga_hsync, vga_vsync;
    logic [4:0]    vga_red, vga_green, vga_blue;
    logic          frame_start;

    int checks = 0;
    int errors = 0;

    bit          fb_const = 1'b0;
    bit          tp_on = 1'b0;
    logic [23:0] pal_model [16];
    logic [3:0]  d1 = 4'd0;
    logic [3:0]  d2 = 4'd0;

    int n_de, n_hs, n_vs, n_fs, max_addr;

    always #5 clock = ~clock;

    display_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .PIX_W(4), .FB_LAT(LAT), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pix_ce     (pix_ce),
        .fb_rd      (fb_rd),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .pal_we     (pal_we),
        .pal_idx    (pal_idx),
        .pal_rgb    (pal_rgb),
`ifdef DISPLAY_SCANOUT_TEST_PATTERN_EN
        .test_mode  (test_mode),
`endif
        .lcd_de     (lcd_de),
        .lcd_hsync  (lcd_hsync),
        .lcd_vsync  (lcd_vsync),
        .lcd_red    (lcd_red),
        .lcd_green  (lcd_green),
        .lcd_blue   (lcd_blue),
        .vga_hsync  (vga_hsync),
        .vga_vsync  (vga_vsync),
        .vga_red    (vga_red),
        .vga_green  (vga_green),
        .vga_blue   (vga_blue),
        .frame_start(frame_start)
    );

    // Framebuffer contents: a scrambled pattern, or a constant 5.
    function automatic logic [3:0] fb_val(input int a);
        return fb_const ? 4'd5 : 4'(a * 7 + a / 16);
    endfunction

    // Two-beat read pipe: address sampled with fb_rd, data advances on pix_ce.
    always @(posedge clock) begin
        if (fb_rd) d1 <= fb_val(int'(fb_addr));
        if (pix_ce) d2 <= d1;
    end
    assign fb_data = d2;

    // Address register value while the raster is at (h,v): number of reads so far.
    function automatic int addr_of(input int h, input int v);
        if (v >= VA) return 0;
        if (h < HA) return v * HA + h;
        return ((v + 1) * HA) % NPIX;
    endfunction

    // Expected observed word at beat state k (k enabled edges since reset release).
    function automatic logic [53:0] exp_word(input int k, input bit en, input bit last_en);
        int h, v, p, ph, pv;
        logic rd, de, hs, vs, fs;
        logic [3:0] idx;
        logic [23:0] rgb;
        h = k % HT;
        v = (k / HT) % VT;
        rd = en && (h < HA) && (v < VA);
        de = 1'b0; hs = 1'b0; vs = 1'b0; fs = 1'b0; rgb = 24'd0;
        if (k >= L) begin
            p  = k - L;
            ph = p % HT;
            pv = (p / HT) % VT;
            de = (ph < HA) && (pv < VA);
            hs = (ph >= HA + HFP) && (ph < HA + HFP + HSW);
            vs = (pv >= VA + VFP) && (pv < VA + VFP + VSW);
            fs = last_en && (p % FRAME == 0);
            idx = tp_on ? 4'((ph / 16) % 16) : fb_val(addr_of(ph, pv));
            if (de) rgb = pal_model[idx];
        end
        return {rd, AW'(addr_of(h, v)), de, ~hs, ~vs, fs, rgb,
                rgb[23:19], rgb[15:11], rgb[7:3], ~hs, ~vs};
    endfunction

    task automatic check(input string tag, input int idx, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_fb_rd"}, 0, 64'(fb_rd), 64'd0);
        check({tag, "_addr"},  0, 64'(fb_addr), 64'd0);
        check({tag, "_de"},    0, 64'(lcd_de), 64'd0);
        check({tag, "_rgb"},   0, 64'({lcd_red, lcd_green, lcd_blue, vga_red, vga_green, vga_blue}), 64'd0);
        check({tag, "_sync"},  0, 64'({lcd_hsync, lcd_vsync, vga_hsync, vga_vsync}), 64'hF);
        check({tag, "_fs"},    0, 64'(frame_start), 64'd0);
    endtask

    // Leaves the bench at edge+1 with reset just released (beat state 0).
    task automatic do_reset();
        reset = 1'b1;
        pix_ce = 1'b1;
        pal_we = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_state("rst");
        reset = 1'b0;
        for (int i = 0; i < 16; i++) pal_model[i] = {3{8'(i * 17)}};
    endtask

    task automatic run_beats(input string tag, input int nclk, input bit toggle,
                             output int o_de, output int o_hs, output int o_vs,
                             output int o_fs, output int o_max);
        int k;
        bit en, last_en;
        logic [53:0] obs;
        k = 0; last_en = 1'b0;
        o_de = 0; o_hs = 0; o_vs = 0; o_fs = 0; o_max = 0;
        for (int c = 0; c < nclk; c++) begin
            en = toggle ? (c % 2 == 0) : 1'b1;
            pix_ce = en;
            #1;
            obs = {fb_rd, fb_addr, lcd_de, lcd_hsync, lcd_vsync, frame_start,
                   lcd_red, lcd_green, lcd_blue, vga_red, vga_green, vga_blue,
                   vga_hsync, vga_vsync};
            check(tag, c, 64'(obs), 64'(exp_word(k, en, last_en)));
            if (en && k >= L && (k - L) < FRAME) begin
                o_de += lcd_de ? 1 : 0;
                o_hs += lcd_hsync ? 0 : 1;
                o_vs += lcd_vsync ? 0 : 1;
            end
            o_fs += frame_start ? 1 : 0;
            if (fb_rd && int'(fb_addr) > o_max) o_max = int'(fb_addr);
            @(posedge clock);
            #1;
            if (en) k++;
            last_en = en;
        end
    endtask

    initial begin
        // Full frame with pix_ce held high.
        fb_const = 1'b0;
        tp_on = 1'b0;
        do_reset();
        run_beats("frame", FRAME + L + 1, 1'b0, n_de, n_hs, n_vs, n_fs, max_addr);
        check("frame_de_beats", 0, 64'(n_de), 64'd240);
        check("frame_hs_beats", 0, 64'(n_hs), 64'd78);
        check("frame_vs_beats", 0, 64'(n_vs), 64'd116);
        check("frame_fs_pulses", 0, 64'(n_fs), 64'd2);
        check("frame_max_addr", 0, 64'(max_addr), 64'd239);

        // pix_ce alternating: same picture, outputs held on idle clocks.
        do_reset();
        run_beats("toggle", 2 * (FRAME + L + 1), 1'b1, n_de, n_hs, n_vs, n_fs, max_addr);
        check("toggle_de_beats", 0, 64'(n_de), 64'd240);
        check("toggle_hs_beats", 0, 64'(n_hs), 64'd78);
        check("toggle_vs_beats", 0, 64'(n_vs), 64'd116);
        check("toggle_fs_pulses", 0, 64'(n_fs), 64'd2);
        check("toggle_max_addr", 0, 64'(max_addr), 64'd239);

        // Palette: index 5 is grey 0x55, then rewritten to red.
        fb_const = 1'b1;
        do_reset();
        run_beats("pal_pre", L + 2, 1'b0, n_de, n_hs, n_vs, n_fs, max_addr);
        check("pal_grey_lcd", 0, 64'({lcd_red, lcd_green, lcd_blue}), 64'h555555);
        check("pal_grey_vga", 0, 64'({vga_red, vga_green, vga_blue}), 64'({5'h0A, 5'h0A, 5'h0A}));
        pal_idx = 4'd5;
        pal_rgb = 24'hFF0000;
        pal_we = 1'b1;
        @(posedge clock);
        #1;
        pal_we = 1'b0;
        check("pal_same_edge_old", 0, 64'({lcd_red, lcd_green, lcd_blue}), 64'h555555);
        @(posedge clock);
        #1;
        check("pal_new_lcd", 0, 64'({lcd_red, lcd_green, lcd_blue}), 64'hFF0000);
        check("pal_new_vga", 0, 64'({vga_red, vga_green, vga_blue}), 64'({5'h1F, 5'h00, 5'h00}));

        // Reset in the middle of visible line 3.
        fb_const = 1'b0;
        do_reset();
        run_beats("pre_rst", 3 * HT + 20, 1'b0, n_de, n_hs, n_vs, n_fs, max_addr);
        check("pre_rst_de", 0, 64'(lcd_de), 64'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_state("midrst");
        reset = 1'b0;
        for (int i = 0; i < 16; i++) pal_model[i] = {3{8'(i * 17)}};
        run_beats("restart", HT + L + 2, 1'b0, n_de, n_hs, n_vs, n_fs, max_addr);

`ifdef DISPLAY_SCANOUT_TEST_PATTERN_EN
        // Bar pattern: 16-pixel grey bars from the horizontal position.
        tp_on = 1'b1;
        test_mode = 1'b1;
        do_reset();
        run_beats("tpat", HT + L, 1'b0, n_de, n_hs, n_vs, n_fs, max_addr);
        tp_on = 1'b0;
        test_mode = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
